rom_block_reader: RTL and testbench

//  Sequencer that reads one 64-byte block (8x8 table) from the single-port ROM and streams it out.

---
 rtl/rom_block_reader_if.sv | 18 +
 rtl/rom_block_reader.sv | 177 +++++++++++++++++
 tb/tb_rom_block_reader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_block_reader_if.sv
// ---------------------------------------------------------------------------
// rom_block_reader_if
//   Byte stream leaving rom_block_reader.
//   Handshake: a beat transfers on a rising clk edge when out_valid and
//   out_ready are both high. Once out_valid is raised, out_data, out_last and
//   out_valid hold steady until that transfer; out_ready may change freely.
//   master : the block reader (drives data/valid/last, observes ready)
//   slave  : the downstream consumer (drives ready)
// ---------------------------------------------------------------------------
interface rom_block_reader_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/rom_block_reader.sv
// ---------------------------------------------------------------------------
// rom_block_reader
//   Reads one 64-byte block (8x8 table) from a single-port registered ROM in
//   raster or JPEG zigzag order and streams the bytes out. A short valid pipe
//   tracks ROM latency and a small shift FIFO absorbs backpressure.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle block request, honoured only in IDLE
//   zigzag     : scan order sampled with start (0 raster, 1 zigzag)
//   rom_a      : ROM address {row[2:0], byte[2:0]}
//   rom_d      : ROM data, valid ROM_LAT cycles after rom_a
//   out_if     : byte stream (data/valid/last out, ready in)
//   busy       : block in progress
//   done       : one-cycle pulse after the final handshake
//   dbg_state  : FSM state (0 IDLE, 1 RUN, 2 DRAIN)
// ---------------------------------------------------------------------------
module rom_block_reader #(
   parameter int ROM_LAT    = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                zigzag,
   output logic [5:0]          rom_a,
   input  logic [7:0]          rom_d,
   rom_block_reader_if.master  out_if,
   output logic                busy,
   output logic                done,
   output logic [1:0]          dbg_state
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

   state_e               state_q;
   logic [5:0]           idx_q;
   logic                 zz_q;
   logic [5:0]           rom_a_q;
   logic [ROM_LAT-1:0]   pipe_v_q;
   logic [ROM_LAT-1:0]   pipe_l_q;
   logic [7:0]           fifo_d_q [FIFO_DEPTH];
   logic [7:0]           fifo_d_d [FIFO_DEPTH];
   logic                 fifo_l_q [FIFO_DEPTH];
   logic                 fifo_l_d [FIFO_DEPTH];
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        count_d;
   logic                 busy_q;
   logic                 done_q;

   int                   inflight;
   int                   wr_pos;
   logic                 pop;
   logic                 push;
   logic                 issue;
   logic [5:0]           idx_nx;

   assign idx_nx = idx_q + 6'd1;

   // rom_a holds the address of the next index to issue; the ROM samples it
   // at the edge where issue is high, so the data lands ROM_LAT edges later.
   always_comb begin
      inflight = 0;
      for (int i = 0; i < ROM_LAT; i++) inflight = inflight + int'(pipe_v_q[i]);
      pop   = (count_q != '0) && out_if.out_ready;
      push  = pipe_v_q[ROM_LAT-1];
      issue = (state_q == S_RUN) &&
              ((int'(count_q) + inflight - int'(pop)) < FIFO_DEPTH);
   end

   // Shift FIFO: slot 0 is the output register. Slots at or above the
   // occupancy are kept at zero so an empty FIFO presents zero data/last.
   always_comb begin
      fifo_d_d = fifo_d_q;
      fifo_l_d = fifo_l_q;
      if (pop) begin
         for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            fifo_d_d[i] = fifo_d_q[i+1];
            fifo_l_d[i] = fifo_l_q[i+1];
         end
         fifo_d_d[FIFO_DEPTH-1] = 8'd0;
         fifo_l_d[FIFO_DEPTH-1] = 1'b0;
      end
      wr_pos = int'(count_q) - int'(pop);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (push && (i == wr_pos)) begin
            fifo_d_d[i] = rom_d;
            fifo_l_d[i] = pipe_l_q[ROM_LAT-1];
         end
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= 6'd0;
         zz_q     <= 1'b0;
         rom_a_q  <= 6'd0;
         pipe_v_q <= '0;
         pipe_l_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d_q[i] <= 8'd0;
            fifo_l_q[i] <= 1'b0;
         end
      end else begin
         done_q <= 1'b0;
         for (int i = ROM_LAT - 1; i > 0; i--) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            pipe_l_q[i] <= pipe_l_q[i-1];
         end
         pipe_v_q[0] <= issue;
         pipe_l_q[0] <= issue && (idx_q == 6'd63);
         fifo_d_q <= fifo_d_d;
         fifo_l_q <= fifo_l_d;
         count_q  <= count_d;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  zz_q    <= zigzag;
                  idx_q   <= 6'd0;
                  rom_a_q <= 6'd0;   // index 0 is address 0 in both orders
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (issue) begin
                  if (idx_q == 6'd63) begin
                     state_q <= S_DRAIN;   // rom_a keeps the final address
                  end else begin
                     idx_q   <= idx_nx;
                     rom_a_q <= zz_q ? ZZ[idx_nx] : idx_nx;
                  end
               end
            end
            S_DRAIN: begin
               if (pop && fifo_l_q[0]) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rom_a            = rom_a_q;
   assign out_if.out_data  = fifo_d_q[0];
   assign out_if.out_last  = fifo_l_q[0];
   assign out_if.out_valid = (count_q != '0);
   assign busy             = busy_q;
   assign done             = done_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_rom_block_reader.sv
// ---------------------------------------------------------------------------
// tb_rom_block_reader
//   Directed bench for rom_block_reader with a registered ROM model
//   (ROM_LAT = 1) and an expected-byte queue filled at each block start.
// ---------------------------------------------------------------------------
module tb_rom_block_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       zigzag = 1'b0;
   logic [5:0] rom_a;
   logic [7:0] rom_d;
   logic       busy;
   logic       done;
   logic [1:0] dbg_state;

   rom_block_reader_if bus ();

   rom_block_reader #(.ROM_LAT(1), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .zigzag    (zigzag),
      .rom_a     (rom_a),
      .rom_d     (rom_d),
      .out_if    (bus),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- ROM model ----------------
   logic [7:0] rom_mem [64];
   always @(posedge clk) rom_d <= rom_mem[rom_a];

   // ---------------- scoreboard state ----------------
   logic [8:0] exp_q [$];
   int         tests_run = 0;
   int         fail_cnt  = 0;
   int         beats     = 0;
   logic [5:0] zz_tab [64];
   bit         mon_on     = 1'b0;
   bit         prev_stall = 1'b0;
   bit         prev_rst   = 1'b1;
   logic [7:0] prev_data;
   logic       prev_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Zigzag order derived by walking anti-diagonals, alternating direction.
   task automatic build_zz();
      int n = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz_tab[n] = 6'(r * 8 + (s - r)); n++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz_tab[n] = 6'(r * 8 + (s - r)); n++; end
         end
      end
   endtask

   // Image 0: value depends on row+col (matches the documented sample bytes).
   // Image 1: all 64 bytes distinct.
   task automatic load_image(input int kind);
      logic [7:0] lut [15];
      lut = '{8'hFF, 8'h80, 8'h6C, 8'h5D, 8'h52, 8'h4A, 8'h43, 8'h3D,
              8'h37, 8'h32, 8'h2D, 8'h28, 8'h23, 8'h1E, 8'h19};
      for (int a = 0; a < 64; a++)
         rom_mem[a] = (kind == 0) ? lut[(a / 8) + (a % 8)] : 8'((a * 37 + 11) % 256);
   endtask

   task automatic push_block(input bit zz);
      for (int i = 0; i < 64; i++) begin
         int a = zz ? int'(zz_tab[i]) : i;
         exp_q.push_back({(i == 63), rom_mem[a]});
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic kick(input bit zz);
      push_block(zz);
      step();
      start  = 1'b1;
      zigzag = zz;
   endtask

   task automatic run_until_done(input string tag, input int max, input bit rnd_ready, input bit toggle_zz);
      bit got = 1'b0;
      int stall = 0;
      for (int n = 0; n < max; n++) begin
         step();
         start = 1'b0;
         if (toggle_zz) zigzag = ~zigzag;
         if (rnd_ready) begin
            if (beats >= 30 && stall < 10) begin
               bus.out_ready = 1'b0;
               stall++;
            end else begin
               bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check(tag, 32'(got), 32'd1);
      bus.out_ready = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rom_a"}, 32'(rom_a), 32'd0);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_data"},  32'(bus.out_data), 32'd0);
      check({tag, "_last"},  32'(bus.out_last), 32'd0);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (mon_on) begin
         if (prev_stall && !prev_rst) begin
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data",  32'(bus.out_data), 32'(prev_data));
            check("stall_last",  32'(bus.out_last), 32'(prev_last));
         end
         if (bus.out_valid && bus.out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("beat_data", 32'(bus.out_data), 32'(e[7:0]));
               check("beat_last", 32'(bus.out_last), 32'(e[8]));
            end
            beats++;
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      prev_rst   = rst;
   end

   // ---------------- directed sequence ----------------
   initial begin
      bus.out_ready = 1'b1;
      build_zz();
      load_image(0);

      // Reset state
      repeat (3) step();
      @(negedge clk);
      check_reset_outputs("reset");
      step();
      rst = 1'b0;
      mon_on = 1'b1;

      // 1: raster, full throughput, cycle-exact timing
      beats = 0;
      kick(1'b0);
      for (int k = 1; k <= 68; k++) begin
         step();
         start = 1'b0;
         @(negedge clk);
         check($sformatf("t1_busy_c%0d", k),  32'(busy), 32'((k >= 1 && k <= 66) ? 1 : 0));
         check($sformatf("t1_valid_c%0d", k), 32'(bus.out_valid), 32'((k >= 3 && k <= 66) ? 1 : 0));
         check($sformatf("t1_last_c%0d", k),  32'(bus.out_last), 32'((k == 66) ? 1 : 0));
         check($sformatf("t1_done_c%0d", k),  32'(done), 32'((k == 67) ? 1 : 0));
      end
      check("t1_beats", 32'(beats), 32'd64);

      // 2: zigzag, rom_a follows the zigzag table one address per cycle
      beats = 0;
      kick(1'b1);
      for (int k = 1; k <= 64; k++) begin
         step();
         start = 1'b0;
         @(negedge clk);
         check($sformatf("t2_rom_a_c%0d", k), 32'(rom_a), 32'(zz_tab[k-1]));
      end
      run_until_done("t2_done", 20, 1'b0, 1'b0);
      check("t2_beats", 32'(beats), 32'd64);

      // 3: random backpressure plus a 10-cycle stall at beat 30
      load_image(1);
      beats = 0;
      kick(1'b0);
      run_until_done("t3_done", 600, 1'b1, 1'b0);
      check("t3_beats", 32'(beats), 32'd64);
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // 4: reset at beat 20, then a fresh zigzag block
      beats = 0;
      kick(1'b1);
      for (int n = 0; n < 100; n++) begin
         step();
         start = 1'b0;
         @(negedge clk);
         if (beats >= 20) break;
      end
      check("t4_reached_beat20", 32'(beats), 32'd20);
      step();
      rst = 1'b1;
      bus.out_ready = 1'b0;
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset_outputs("t4_after_rst");
      for (int n = 0; n < 4; n++) begin
         step();
         @(negedge clk);
         check("t4_no_done", 32'(done), 32'd0);
      end
      beats = 0;
      kick(1'b1);
      run_until_done("t4_done", 200, 1'b0, 1'b0);
      check("t4_beats", 32'(beats), 32'd64);

      // 5: start while busy ignored; start in the done cycle accepted
      beats = 0;
      kick(1'b0);
      for (int k = 1; k <= 67; k++) begin
         step();
         start = (k == 10 || k == 30 || k == 50 || k == 67);
         if (k == 67) begin
            zigzag = 1'b1;
            push_block(1'b1);
         end
         @(negedge clk);
         if (k == 67) check("t5_done_c67", 32'(done), 32'd1);
      end
      run_until_done("t5_done2", 200, 1'b0, 1'b0);
      check("t5_beats", 32'(beats), 32'd128);

      // 6: zigzag toggling mid-block has no effect
      beats = 0;
      kick(1'b0);
      run_until_done("t6_done", 200, 1'b0, 1'b1);
      check("t6_beats", 32'(beats), 32'd64);

      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      step();
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule
